// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller that runs a 1W/1R register file as
// a show-ahead circular FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguishable without a separate occupancy counter.
module fifo_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  err_clr,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ovf_err,
   output logic                  udf_err
);

   localparam logic [ADDR_WIDTH:0] AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                push_acc;
   logic                pop_acc;
   logic                ovf_set;
   logic                udf_set;

   // Flags and addresses come from registered pointers only.
   assign w_addr      = wr_ptr[ADDR_WIDTH-1:0];
   assign r_addr      = rd_ptr[ADDR_WIDTH-1:0];
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
   assign count       = wr_ptr - rd_ptr;
   assign almost_full = (count >= AFULL);

   // A push into a full FIFO is still taken when a pop frees the head slot
   // in the same cycle; the consumer reads the old word before the edge.
   assign push_acc = push & (~full | pop) & ~clr;
   assign pop_acc  = pop & ~empty & ~clr;

   // Write enable is combinational so it lands on the same edge as the
   // producer's data; held low during reset since pointers are not moving.
   assign w_en = push_acc & rst_n;

   assign ovf_set = push & full & ~pop & ~clr;
   assign udf_set = pop & empty & ~clr;

   // Pointer update: flush returns both to 0, otherwise advance on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(push_acc);
         rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(pop_acc);
      end
   end

   // Sticky error flags; a new error in the err_clr cycle wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         ovf_err <= ovf_set | (ovf_err & ~err_clr);
         udf_err <= udf_set | (udf_err & ~err_clr);
      end
   end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller that sequences a single-write, single-read register file as a circular FIFO. It drives the file's write enable, write address and read address, and tracks occupancy with full/empty/almost-full flags, a count, and sticky overflow/underflow error flags. It sits between a producer/consumer pair and the register file. Read data comes straight off the file's asynchronous read port, so the FIFO behaves as show-ahead: the head word is visible whenever `empty` is low.

## Interface
- `ADDR_WIDTH`, 4, address width; depth = 2**ADDR_WIDTH entries
- `AFULL_LEVEL`, 2**ADDR_WIDTH-2, occupancy at or above which `almost_full` asserts; legal range 1..2**ADDR_WIDTH
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous flush; empties the FIFO
- `push`  in  1  producer requests a write this cycle; data goes directly to the file's `w_data`
- `pop`  in  1  consumer takes the head word this cycle
- `err_clr`  in  1  synchronous clear of sticky error flags
- `w_en`  out  1  register-file write enable
- `w_addr`  out  ADDR_WIDTH  register-file write address
- `r_addr`  out  ADDR_WIDTH  register-file read address (head of FIFO)
- `full`  out  1  occupancy == 2**ADDR_WIDTH
- `empty`  out  1  occupancy == 0
- `almost_full`  out  1  occupancy >= AFULL_LEVEL
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
- `ovf_err`  out  1  sticky: a push was rejected
- `udf_err`  out  1  sticky: a pop was rejected

## Operation
- State: `wr_ptr` and `rd_ptr`, each ADDR_WIDTH+1 bits; the MSB is the wrap bit. Also holds `ovf_err` and `udf_err`.
- Address outputs:
  - `w_addr` = `wr_ptr[ADDR_WIDTH-1:0]`
  - `r_addr` = `rd_ptr[ADDR_WIDTH-1:0]`
- Occupancy flags:
  - `empty` = (`wr_ptr` == `rd_ptr`)
  - `full` = (low bits equal) and (wrap bits differ)
  - `count` = `wr_ptr` - `rd_ptr`, modulo 2**(ADDR_WIDTH+1)
  - `almost_full` = (`count` >= AFULL_LEVEL)
- Acceptance:
  - `push_acc` = `push` & (~`full` | `pop`) & ~`clr`
  - `pop_acc` = `pop` & ~`empty` & ~`clr`
- `w_en` = `push_acc`, combinational. `w_en` is forced 0 while `rst_n` is low.
- On each edge:
  - `wr_ptr` += `push_acc`; `rd_ptr` += `pop_acc`
  - Pointers wrap naturally through the extra bit; no special-case logic at the top of the address range.
- Full with push and pop together: both are accepted and `count` is unchanged. The consumer reads the old word asynchronously in that cycle; the new word is written at the edge.
- Empty with push and pop together: the push is accepted and the pop is rejected. `udf_err` sets. `count` becomes 1.
- Errors:
  - `ovf_err` sets on `push` & `full` & ~`pop` & ~`clr`.
  - `udf_err` sets on `pop` & `empty` & ~`clr`.
  - `err_clr` clears both flags. If a new error occurs in the same cycle as `err_clr`, the set wins.
- `clr` has priority over `push`/`pop`: both pointers go to 0 at the edge and `w_en` is 0 that cycle. Error flags are untouched by `clr`.
- Reset (async, `rst_n` low):
  - pointers = 0
  - `empty`=1, `full`=0, `count`=0, `almost_full`=0
  - `ovf_err`=0, `udf_err`=0
  - `w_en`=0, `w_addr`=0, `r_addr`=0
- Reset asserted mid-operation discards all contents immediately. The file contents are not cleared, only the pointers.

## Timing
- Every output except `w_en` is a function of registered state only: stable the whole cycle and updated one edge after the causing event.
- Push to visible: a word pushed at edge N appears on the file's `r_data` after edge N (when the FIFO was empty). `empty` falls after edge N.
- Pop: the head word is valid combinationally during the cycle `pop` is high; `r_addr` advances after the edge.
- `w_en`, `w_addr` and the producer's data must meet setup to the same edge as the file's write.
- `full`/`empty`/`count` change by at most one per edge; simultaneous accepted push and pop produce no change.
- Release of `rst_n` is assumed synchronized externally; the first edge after release may accept a push.

## Test plan
- Reset and single word: hold `rst_n` low → `empty`=1, `count`=0, `w_en`=0. Release, push 0xA5 once → next cycle `empty`=0, `count`=1, `r_addr`=0, head = 0xA5. Pop → `empty`=1.
- Fill and wrap, ADDR_WIDTH=4: push 16 → `full`=1, `count`=16, `almost_full` asserted at `count`=14. Pop 8, push 8 → `w_addr` wraps 15→0→7, data order preserved.
- Overflow: when full, push without pop → `w_en`=0, `count` stays 16, `ovf_err`=1. Push and pop together when full → both accepted, `count`=16, no error.
- Underflow: when empty, pop → `udf_err`=1, `r_addr` unchanged. Push and pop together when empty → `count`=1, `udf_err`=1. Then `err_clr` with an error-free cycle → both errors 0.
- Flush: with 5 entries, assert `clr` together with `push` → `w_en`=0, next cycle `count`=0, `empty`=1, pointers 0, sticky errors preserved.
- Async reset mid-stream: with 9 entries, pulse `rst_n` low between edges → outputs reach reset values immediately, without waiting for `clk`.
